// File: rtl/sym_recombine_if.sv
// Handshake bundle for sym_recombine: offset/sign input, core-result input
// and saturated activation output, each on its own valid/ready pair.
interface sym_recombine_if #(
  parameter int W = 12
);
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_in;
  logic         sign_in;

  logic         f_valid;
  logic         f_ready;
  logic [W-1:0] f_in;

  logic         y_valid;
  logic         y_ready;
  logic [W-1:0] y_out;
  logic         y_sat;

  modport slave (
    input  s_valid, s_in, sign_in, f_valid, f_in, y_ready,
    output s_ready, f_ready, y_valid, y_out, y_sat
  );

  modport master (
    output s_valid, s_in, sign_in, f_valid, f_in, y_ready,
    input  s_ready, f_ready, y_valid, y_out, y_sat
  );
endinterface

// File: rtl/sym_recombine.sv
// Reconstruction stage: queues symmetry offset/sign until the core returns f(|x|),
// then emits y = s +/- f with saturation on a registered valid/ready output.
module sym_recombine #(
  parameter int M         = 4,
  parameter int N         = 8,
  parameter int FUNC_TYPE = 0,
  parameter int DEPTH     = 4
) (
  input  logic           clk,
  input  logic           rst,
  sym_recombine_if.slave bus
);
  localparam int W   = M + N;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam bit NEG = (FUNC_TYPE != 2);

  logic [W-1:0]      s_mem_q  [DEPTH];
  logic              sg_mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              y_valid_q, y_valid_d;
  logic              y_sat_q, y_sat_d;
  logic [W-1:0]      y_out_q, y_out_d;

  logic              s_ready, f_ready;
  logic              push, pop;
  logic signed [W:0] s_ext, t_ext, sum;
  logic              sat;
  logic [W-1:0]      y_clip;

  // f_ready looks only at registered state and y_ready, never at f_valid/s_valid.
  assign s_ready = (count_q < CW'(DEPTH));
  assign f_ready = (count_q != '0) && (!y_valid_q || bus.y_ready);
  assign push    = bus.s_valid && s_ready;
  assign pop     = bus.f_valid && f_ready;

  assign bus.s_ready = s_ready;
  assign bus.f_ready = f_ready;
  assign bus.y_valid = y_valid_q;
  assign bus.y_out   = y_out_q;
  assign bus.y_sat   = y_sat_q;

  // One guard bit: overflow shows up as the top two sum bits disagreeing.
  always_comb begin
    s_ext = signed'({s_mem_q[rd_ptr_q][W-1], s_mem_q[rd_ptr_q]});
    t_ext = signed'({bus.f_in[W-1], bus.f_in});
    if (NEG && sg_mem_q[rd_ptr_q]) t_ext = -t_ext;
    sum = s_ext + t_ext;
    sat = sum[W] ^ sum[W-1];
    if (sat) y_clip = {sum[W], {(W-1){~sum[W]}}};
    else     y_clip = sum[W-1:0];
  end

  // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    y_valid_d = y_valid_q;
    y_out_d   = y_out_q;
    y_sat_d   = y_sat_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (pop) begin
      y_valid_d = 1'b1;
      y_out_d   = y_clip;
      y_sat_d   = sat;
    end else if (y_valid_q && bus.y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  // NOTE: entry storage has no reset; count_q gates every read, so stale data is never used.
  always_ff @(posedge clk) begin
    if (push) begin
      s_mem_q[wr_ptr_q]  <= bus.s_in;
      sg_mem_q[wr_ptr_q] <= bus.sign_in;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      y_valid_q <= 1'b0;
      y_out_q   <= '0;
      y_sat_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      y_valid_q <= y_valid_d;
      y_out_q   <= y_out_d;
      y_sat_q   <= y_sat_d;
    end
  end
endmodule

// File: tb/tb_sym_recombine.sv
// Directed bench: three sym_recombine instances (FUNC_TYPE 0/1/2) share one stimulus
// stream; each scenario task compares outputs against hand-computed values.
module tb_sym_recombine;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid, sign_in, f_valid, y_ready;
  logic [W-1:0] s_in, f_in;

  logic         s_ready [3];
  logic         f_ready [3];
  logic         y_valid [3];
  logic [W-1:0] y_out   [3];
  logic         y_sat   [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sym_recombine_if #(.W(W)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].s_valid = s_valid;
    assign bus[g].s_in    = s_in;
    assign bus[g].sign_in = sign_in;
    assign bus[g].f_valid = f_valid;
    assign bus[g].f_in    = f_in;
    assign bus[g].y_ready = y_ready;
    assign s_ready[g]     = bus[g].s_ready;
    assign f_ready[g]     = bus[g].f_ready;
    assign y_valid[g]     = bus[g].y_valid;
    assign y_out[g]       = bus[g].y_out;
    assign y_sat[g]       = bus[g].y_sat;

    sym_recombine #(.M(4), .N(8), .FUNC_TYPE(g), .DEPTH(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; sign_in = 1'b0; f_valid = 1'b0; y_ready = 1'b1;
    s_in = '0; f_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      n_chk++; if (s_ready[g] !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready[%0d]: got %b want 1", g, s_ready[g]); end
      n_chk++; if (f_ready[g] !== 1'b0) begin n_fail++; $display("FAIL reset_f_ready[%0d]: got %b want 0", g, f_ready[g]); end
      n_chk++; if (y_valid[g] !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid[%0d]: got %b want 0", g, y_valid[g]); end
      n_chk++; if (y_out[g] !== '0 || y_sat[g] !== 1'b0) begin n_fail++; $display("FAIL reset_y[%0d]: got %0d/%b want 0/0", g, y_out[g], y_sat[g]); end
    end
  endtask

  // Columns: s, sign, f, y(FT0), y(FT1), y(FT2), sat(FT0), sat(FT1), sat(FT2)
  task automatic test_combine();
    int tbl [6][9];
    tbl = '{'{  256, 1,   192,    64,    64,   448, 0, 0, 0},
            '{ -384, 1,   100,  -484,  -484,  -284, 0, 0, 0},
            '{    0, 1,   300,  -300,  -300,   300, 0, 0, 0},
            '{ 2000, 0,   100,  2047,  2047,  2047, 1, 1, 1},
            '{-2048, 1,     1, -2048, -2048, -2047, 1, 1, 0},
            '{ 2047, 1, -2048,  2047,  2047,    -1, 1, 1, 0}};
    y_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      s_valid = 1'b1; s_in = W'(tbl[v][0]); sign_in = (tbl[v][1] != 0);
      tick();
      s_valid = 1'b0; f_valid = 1'b1; f_in = W'(tbl[v][2]);
      #1;
      n_chk++; if (f_ready[2] !== 1'b1) begin n_fail++; $display("FAIL combine_f_ready v%0d: got %b want 1", v, f_ready[2]); end
      tick();
      f_valid = 1'b0;
      for (int g = 0; g < 3; g++) begin
        n_chk++; if (y_valid[g] !== 1'b1) begin n_fail++; $display("FAIL combine_y_valid v%0d ft%0d: got %b want 1", v, g, y_valid[g]); end
        n_chk++; if (y_out[g] !== W'(tbl[v][3+g])) begin n_fail++; $display("FAIL combine_y_out v%0d ft%0d: got %0d want %0d", v, g, $signed(y_out[g]), tbl[v][3+g]); end
        n_chk++; if (y_sat[g] !== 1'(tbl[v][6+g])) begin n_fail++; $display("FAIL combine_y_sat v%0d ft%0d: got %b want %0d", v, g, y_sat[g], tbl[v][6+g]); end
      end
      tick();
      n_chk++; if (y_valid[2] !== 1'b0) begin n_fail++; $display("FAIL combine_drain v%0d: got %b want 0", v, y_valid[2]); end
    end
  endtask

  task automatic test_fifo_full();
    y_ready = 1'b1; sign_in = 1'b0; s_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      s_in = W'(10 * k);
      tick();
    end
    n_chk++; if (s_ready[2] !== 1'b0) begin n_fail++; $display("FAIL full_s_ready: got %b want 0", s_ready[2]); end
    // Pop while full with s_valid high: the push must still be refused.
    s_in = W'(50); f_valid = 1'b1; f_in = W'(1);
    #1;
    n_chk++; if (f_ready[2] !== 1'b1) begin n_fail++; $display("FAIL full_f_ready: got %b want 1", f_ready[2]); end
    tick();
    s_valid = 1'b0;
    n_chk++; if (y_out[2] !== W'(11)) begin n_fail++; $display("FAIL full_pop1: got %0d want 11", y_out[2]); end
    n_chk++; if (s_ready[2] !== 1'b1) begin n_fail++; $display("FAIL full_after_pop_s_ready: got %b want 1", s_ready[2]); end
    for (int k = 2; k <= 4; k++) begin
      f_in = W'(k);
      tick();
      n_chk++; if (y_valid[0] !== 1'b1 || y_out[0] !== W'(11 * k)) begin n_fail++; $display("FAIL full_pop%0d: got %b/%0d want 1/%0d", k, y_valid[0], y_out[0], 11 * k); end
    end
    #1;
    n_chk++; if (f_ready[2] !== 1'b0) begin n_fail++; $display("FAIL empty_f_ready: got %b want 0", f_ready[2]); end
    tick();
    n_chk++; if (y_valid[2] !== 1'b0) begin n_fail++; $display("FAIL empty_no_pop: got %b want 0", y_valid[2]); end
    s_valid = 1'b1; s_in = W'(7);
    #1;
    n_chk++; if (f_ready[2] !== 1'b0) begin n_fail++; $display("FAIL no_bypass_f_ready: got %b want 0", f_ready[2]); end
    tick();
    s_valid = 1'b0; f_in = W'(9);
    #1;
    n_chk++; if (f_ready[2] !== 1'b1) begin n_fail++; $display("FAIL push_landed_f_ready: got %b want 1", f_ready[2]); end
    tick();
    f_valid = 1'b0;
    n_chk++; if (y_out[2] !== W'(16)) begin n_fail++; $display("FAIL push_landed_y_out: got %0d want 16", y_out[2]); end
    tick();
  endtask

  task automatic test_simul_push_pop();
    y_ready = 1'b1; sign_in = 1'b0; s_valid = 1'b1;
    s_in = W'(100); tick();
    s_in = W'(200); tick();
    s_in = W'(300); f_valid = 1'b1; f_in = W'(5);
    tick();
    s_valid = 1'b0;
    n_chk++; if (y_out[2] !== W'(105)) begin n_fail++; $display("FAIL simul_pop1: got %0d want 105", y_out[2]); end
    tick();
    n_chk++; if (y_out[2] !== W'(205)) begin n_fail++; $display("FAIL simul_pop2: got %0d want 205", y_out[2]); end
    tick();
    n_chk++; if (y_out[2] !== W'(305)) begin n_fail++; $display("FAIL simul_pop3: got %0d want 305", y_out[2]); end
    #1;
    n_chk++; if (f_ready[2] !== 1'b0) begin n_fail++; $display("FAIL simul_count: f_ready got %b want 0", f_ready[2]); end
    f_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    y_ready = 1'b1; sign_in = 1'b0; s_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      s_in = W'(k);
      tick();
    end
    s_valid = 1'b0; y_ready = 1'b0; f_valid = 1'b1; f_in = W'(100);
    tick();
    n_chk++; if (y_out[2] !== W'(101)) begin n_fail++; $display("FAIL stall_first: got %0d want 101", y_out[2]); end
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++; if (f_ready[2] !== 1'b0) begin n_fail++; $display("FAIL stall_f_ready c%0d: got %b want 0", c, f_ready[2]); end
      tick();
      n_chk++; if (y_valid[2] !== 1'b1 || y_out[2] !== W'(101)) begin n_fail++; $display("FAIL stall_hold c%0d: got %b/%0d want 1/101", c, y_valid[2], y_out[2]); end
    end
    y_ready = 1'b1;
    #1;
    n_chk++; if (f_ready[2] !== 1'b1) begin n_fail++; $display("FAIL release_f_ready: got %b want 1", f_ready[2]); end
    tick();
    n_chk++; if (y_valid[2] !== 1'b1 || y_out[2] !== W'(102)) begin n_fail++; $display("FAIL b2b_1: got %b/%0d want 1/102", y_valid[2], y_out[2]); end
    tick();
    n_chk++; if (y_valid[2] !== 1'b1 || y_out[2] !== W'(103)) begin n_fail++; $display("FAIL b2b_2: got %b/%0d want 1/103", y_valid[2], y_out[2]); end
    f_valid = 1'b0;
    tick();
    n_chk++; if (y_valid[2] !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", y_valid[2]); end
  endtask

  task automatic test_reset_mid();
    y_ready = 1'b1; sign_in = 1'b0; s_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      s_in = W'(k);
      tick();
    end
    s_valid = 1'b0; y_ready = 1'b0; f_valid = 1'b1; f_in = W'(10);
    tick();
    f_valid = 1'b0;
    n_chk++; if (y_valid[2] !== 1'b1 || y_out[2] !== W'(11)) begin n_fail++; $display("FAIL pre_reset: got %b/%0d want 1/11", y_valid[2], y_out[2]); end
    rst = 1'b1;
    tick();
    n_chk++; if (y_valid[2] !== 1'b0) begin n_fail++; $display("FAIL midrst_y_valid: got %b want 0", y_valid[2]); end
    n_chk++; if (s_ready[2] !== 1'b1) begin n_fail++; $display("FAIL midrst_s_ready: got %b want 1", s_ready[2]); end
    n_chk++; if (f_ready[2] !== 1'b0) begin n_fail++; $display("FAIL midrst_f_ready: got %b want 0", f_ready[2]); end
    rst = 1'b0; f_valid = 1'b1; f_in = W'(20); y_ready = 1'b1;
    #1;
    n_chk++; if (f_ready[2] !== 1'b0) begin n_fail++; $display("FAIL postrst_f_ready: got %b want 0", f_ready[2]); end
    tick();
    n_chk++; if (y_valid[2] !== 1'b0) begin n_fail++; $display("FAIL postrst_no_pop: got %b want 0", y_valid[2]); end
    s_valid = 1'b1; s_in = W'(7);
    tick();
    s_valid = 1'b0;
    #1;
    n_chk++; if (f_ready[2] !== 1'b1) begin n_fail++; $display("FAIL postrst_push_f_ready: got %b want 1", f_ready[2]); end
    tick();
    f_valid = 1'b0;
    n_chk++; if (y_out[2] !== W'(27)) begin n_fail++; $display("FAIL postrst_y_out: got %0d want 27", y_out[2]); end
    tick();
  endtask

  initial begin
    test_reset();
    test_combine();
    test_fifo_full();
    test_simul_push_pop();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sym_recombine.md
# sym_recombine

Downstream reconstruction stage of the symmetry-aware activation datapath. It holds the symmetry offset and sign produced by the symmetry stage (`Sym`) in a small FIFO until the approximation core returns f(|x|). It then forms the final activation y = s + (±f) with saturation and presents it on a valid/ready output. The FIFO absorbs the variable core latency, so offsets and core results can arrive on independent handshakes.

## Interface
- `M`, 4, integer bits incl. sign (same as symmetry stage)
- `N`, 8, fraction bits
- `FUNC_TYPE`, 0, 0 = odd function (tanh), 1 = sigmoid-like (1 − f), 2 = x + f form (GELU/SiLU)
- `DEPTH`, 4, offset FIFO entries, power of two, ≥ 2
- W = M+N throughout.

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `s_valid`  in  1  offset entry valid
- `s_ready`  out  1  FIFO can accept
- `s_in`  in  W  signed offset from symmetry stage
- `sign_in`  in  1  sign of original x
- `f_valid`  in  1  core result valid
- `f_ready`  out  1  block accepts core result
- `f_in`  in  W  signed f(|x|) from core
- `y_valid`  out  1  result valid
- `y_ready`  in  1  downstream accepts result
- `y_out`  out  W  signed final activation
- `y_sat`  out  1  y_out was saturated (qualified by `y_valid`)

## Operation
- FIFO of {s_in, sign_in}, DEPTH entries, read/write pointers log2(DEPTH) bits wrapping modulo DEPTH, count register 0..DEPTH.
- Push when `s_valid && s_ready`. `s_ready = (count < DEPTH)`, registered state only. No push when full, even if a pop occurs the same cycle.
- Pop when `f_valid && f_ready`. `f_ready = (count != 0) && (!y_valid || y_ready)`.
- Same-cycle push and pop: count unchanged, both pointers advance.
- An entry pushed in cycle t is poppable from t+1 onward. No same-cycle bypass.
- Results pair with offsets strictly in order: the k-th accepted f pairs with the k-th accepted offset.
- Combine on pop, using head entry {s, sg}:
  - NEG = (FUNC_TYPE != 2).
  - t = (NEG && sg) ? −f_in : f_in.
  - sum = s + t, computed in W+1 bits with both operands sign-extended.
- Saturate sum to [−2^(W−1), 2^(W−1)−1]. `y_sat` = 1 when clipped.
- Output register: loaded on pop, setting `y_valid` = 1.
  - Cleared when `y_ready && y_valid` and no pop that cycle.
  - Pop with output draining the same cycle reloads the register, so `y_valid` stays 1.
- `y_out`/`y_sat` hold stable while `y_valid && !y_ready`.
- f arriving while the FIFO is empty is not accepted (`f_ready` = 0), and the core must hold it. Ungated data is never dropped.

## Timing
- Reset (async assert, sync-safe deassert): count = 0, pointers = 0, `y_valid` = 0, `y_out` = 0, `y_sat` = 0.
  - Reset values: `s_ready` = 1, `f_ready` = 0.
- Reset mid-operation discards all FIFO entries and any pending result.
- Latency: f handshake in cycle t → `y_valid` = 1 with result in cycle t+1.
- Throughput: one result per cycle while `y_ready` = 1 and FIFO non-empty.
- Backpressure: `y_ready` low with `y_valid` high → `f_ready` = 0 the same cycle (combinational from registered state and `y_ready`).
- `s_ready` depends only on registered count. `f_ready` has no combinational path from `f_valid` or `s_valid`.

## Test plan
- FUNC_TYPE=1, M=4, N=8: push s=256, sign=1; next cycle f=192 → y_out=64, y_sat=0, one cycle after the f handshake.
- FUNC_TYPE=2: push s=−384, sign=1; f=100 → y_out=−284. FUNC_TYPE=0: s=0, sign=1, f=300 → y_out=−300.
- Saturation, FUNC_TYPE=2: s=2000, sign=0, f=100 → y_out=2047, y_sat=1. FUNC_TYPE=0: s=−2048, sign=1, f=1 → y_out=−2048, y_sat=1.
- DEPTH=4, FIFO behaviour:
  - 4 pushes with no f → s_ready=0 after the 4th, and a 5th s_valid is not accepted.
  - 4 f's pop in push order, with results matching each offset.
  - Simultaneous push/pop at count=2 leaves count=2.
- Stalls:
  - y_ready=0 for 3 cycles with y_valid=1 → y_out stable, f_ready=0, no pop.
  - Release → back-to-back results, one per cycle.
  - f_valid with FIFO empty → f_ready=0 until a push lands.
- Assert rst with 3 entries queued and y_valid=1 → next cycle y_valid=0, s_ready=1, f_ready=0. A subsequent f is not accepted until a new push.
